// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampled UART receiver. It majority-votes each bit and delivers words over valid/ready.
// Define UART_RX_FIFO_EN to buffer words in a FIFO_DEPTH-entry FIFO instead of a single holding register.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a low sample (or for high after a break)
// ST_START | confirming the start bit at its centre
// ST_DATA  | shifting in DATA_BITS votes, LSB first
// ST_PAR   | checking the parity slot
// ST_STOP  | checking stop slot(s); the last centre pushes the word

module uart_rx_gen #(
    parameter int SYS_CLK    = 14000000,
    parameter int RATE       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = SYS_CLK / (RATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int WW  = DATA_BITS + 2;

    localparam logic [TW-1:0] T_LAST  = TW'(DIV - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SMP_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_DEC  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    B_DLAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_SLAST  = 4'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam bit CFG_OK = (DIV >= 1) && (OVERSAMPLE % 2 == 0) &&
                            (OVERSAMPLE >= 8) && (OVERSAMPLE <= 32) &&
                            (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                            (PARITY >= 0) && (PARITY <= 2) &&
                            (STOP_BITS == 1 || STOP_BITS == 2) &&
                            (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("uart_rx_gen: unsupported parameter set");
        end
    endgenerate

    logic r_sync1;
    logic r_sync2;
    logic w_sdin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sdin = r_sync2;

    logic [TW-1:0] r_tcnt;
    logic          w_tick;

    assign w_tick = (r_tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    logic [2:0]           r_state;
    logic [SW-1:0]        r_scnt;
    logic [3:0]           r_bcnt;
    logic                 r_v0;
    logic                 r_v1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_brk;

    logic [SW-1:0] w_scnt_nxt;
    logic          w_centre;
    logic          w_vote;
    logic          w_par_x;
    logic          w_perr_calc;
    logic          w_last_stop;
    logic          w_push;
    logic [WW-1:0] w_word;

    assign w_scnt_nxt  = (r_scnt == SMP_LAST) ? '0 : r_scnt + 1'b1;
    assign w_centre    = (w_scnt_nxt == SMP_DEC);
    assign w_vote      = (r_v0 & r_v1) | (r_v0 & w_sdin) | (r_v1 & w_sdin);
    assign w_par_x     = ^{r_shift, w_vote};
    assign w_perr_calc = (PARITY == 1) ? ~w_par_x : w_par_x;
    assign w_last_stop = (r_bcnt == B_SLAST);
    assign w_push      = w_tick && (r_state == ST_STOP) && w_centre && w_last_stop;
    assign w_word      = {r_ferr | ~w_vote, r_perr, r_shift};

    // The state always names the slot whose centre comes next; scnt keeps running across slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_scnt  <= '0;
            r_bcnt  <= '0;
            r_v0    <= 1'b1;
            r_v1    <= 1'b1;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_brk   <= 1'b0;
        end else if (w_tick) begin
            if (r_state == ST_IDLE) begin
                if (r_brk) begin
                    if (w_sdin) begin
                        r_brk <= 1'b0;
                    end
                end else if (!w_sdin) begin
                    r_state <= ST_START;
                    r_scnt  <= '0;
                end
            end else begin
                r_scnt <= w_scnt_nxt;
                if (w_scnt_nxt == SMP_V0) begin
                    r_v0 <= w_sdin;
                end
                if (w_scnt_nxt == SMP_V1) begin
                    r_v1 <= w_sdin;
                end
                if (w_centre) begin
                    case (r_state)
                        ST_START: begin
                            if (w_vote) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_DATA;
                                r_bcnt  <= '0;
                                r_ferr  <= 1'b0;
                                r_perr  <= 1'b0;
                            end
                        end
                        ST_DATA: begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                            if (r_bcnt == B_DLAST) begin
                                r_bcnt  <= '0;
                                r_state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                            end else begin
                                r_bcnt <= r_bcnt + 1'b1;
                            end
                        end
                        ST_PAR: begin
                            r_perr  <= w_perr_calc;
                            r_state <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (!w_vote) begin
                                r_ferr <= 1'b1;
                            end
                            if (w_last_stop) begin
                                r_state <= ST_IDLE;
                                r_brk   <= r_ferr | ~w_vote;
                            end else begin
                                r_bcnt <= r_bcnt + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    logic          r_valid;
    logic [WW-1:0] r_word;
    logic          r_overrun;
    logic          w_pop;

    assign w_pop = r_valid && ready;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] w_rd_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_full;
    logic          w_push_ok;
    logic [WW-1:0] w_head_nxt;

    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_rd_nxt  = r_rd + 1'b1;
    assign w_cnt_nxt = r_cnt + CW'(w_push_ok) - CW'(w_pop);

    // r_word mirrors mem[rd]; an incoming word becomes head directly when nothing older remains.
    always_comb begin
        w_head_nxt = r_word;
        if (w_cnt_nxt != '0) begin
            if (w_pop) begin
                w_head_nxt = (r_cnt > CW'(1)) ? r_mem[w_rd_nxt] : w_word;
            end else if (r_cnt == '0) begin
                w_head_nxt = w_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && !w_push_ok;
            if (w_push_ok) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            r_word  <= w_head_nxt;
        end
    end
`else
    logic w_push_ok;

    assign w_push_ok = w_push && (!r_valid || ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && !w_push_ok;
            if (w_push_ok) begin
                r_word  <= w_word;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

    assign dout       = r_word[DATA_BITS-1:0];
    assign frame_err  = r_word[WW-1];
    assign parity_err = r_word[WW-2];
    assign valid      = r_valid;
    assign overrun    = r_overrun;

endmodule
